decode_stage: RTL

IF/ID pipeline latch plus decode for the 64-bit LEGv8 datapath. Sits directly downstream of fetch: it captures the 32-bit instruction and its PC each cycle, holds them on stall, and kills them on flush. It also owns the 32 x 64-bit register file, with XZR hard-wired to zero and same-cycle write-back bypass. It produces operands, a sign-extended immediate and the destination register for the execute stage.

---
 rtl/decode_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline latch, LEGv8 field decode, and the 32 x WORD
// register file. XZR (index 31) always reads zero. A write-back to the register
// being read is visible in the same cycle.
module decode_stage #(
   parameter int WORD      = 64,
   parameter int INSTR_LEN = 32,
   parameter int NREGS     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_LEN-1:0] instruction,
   input  logic [WORD-1:0]      pc_in,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 wb_en,
   input  logic [4:0]           wb_addr,
   input  logic [WORD-1:0]      wb_data,
   output logic [10:0]          opcode,
   output logic [4:0]           rd,
   output logic [WORD-1:0]      read_data1,
   output logic [WORD-1:0]      read_data2,
   output logic [WORD-1:0]      sign_ext_imm,
   output logic [WORD-1:0]      pc_out,
   output logic                 out_valid
);

   localparam logic [4:0] XZR = 5'd31;

   logic [INSTR_LEN-1:0] r_ir;
   logic [WORD-1:0]      r_pc;
   logic                 r_v;
   logic [WORD-1:0]      r_regs [NREGS];

   logic                 w_is_stur;
   logic                 w_is_cb;
   logic                 w_is_b;
   logic                 w_is_d;
   logic                 w_is_i;
   logic [4:0]           w_rn;
   logic [4:0]           w_r2;
   logic                 w_wr_ok;

   // IF/ID latch: reset, then flush (beats stall), then stall hold, then capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ir <= '0;
         r_pc <= '0;
         r_v  <= 1'b0;
      end else if (flush) begin
         r_ir <= '0;
         r_v  <= 1'b0;
      end else if (stall) begin
         r_ir <= r_ir;
         r_pc <= r_pc;
         r_v  <= r_v;
      end else begin
         r_ir <= instruction;
         r_pc <= pc_in;
         r_v  <= in_valid;
      end
   end

   assign w_wr_ok = wb_en && (wb_addr != XZR);

   // Register file: cleared on reset; only the write-back port changes it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[wb_addr] <= wb_data;
      end else begin
         r_regs[wb_addr] <= r_regs[wb_addr];
      end
   end

   // Format detection from the latched instruction.
   always_comb begin
      w_is_stur = (r_ir[31:21] == 11'b11111000000);
      w_is_cb   = (r_ir[31:25] == 7'b1011010);
      w_is_b    = (r_ir[31:26] == 6'b000101);
      w_is_d    = (r_ir[31:23] == 9'b111110000) && (r_ir[21] == 1'b0);
      w_is_i    = (r_ir[31:22] == 10'b1001000100) || (r_ir[31:22] == 10'b1101000100);
      w_rn      = r_ir[9:5];
      // Stores and compare-branches carry their data register in the Rt field.
      if (w_is_stur || w_is_cb) begin
         w_r2 = r_ir[4:0];
      end else begin
         w_r2 = r_ir[20:16];
      end
   end

   // Immediate extraction; branch offsets stay unshifted for execute.
   always_comb begin
      sign_ext_imm = '0;
      if (w_is_b) begin
         sign_ext_imm = {{(WORD-26){r_ir[25]}}, r_ir[25:0]};
      end else if (w_is_cb) begin
         sign_ext_imm = {{(WORD-19){r_ir[23]}}, r_ir[23:5]};
      end else if (w_is_d) begin
         sign_ext_imm = {{(WORD-9){r_ir[20]}}, r_ir[20:12]};
      end else if (w_is_i) begin
         sign_ext_imm = {{(WORD-12){1'b0}}, r_ir[21:10]};
      end else begin
         sign_ext_imm = '0;
      end
   end

   // Operand reads: XZR is zero, then write-first bypass, then stored value.
   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      if (w_rn == XZR) begin
         read_data1 = '0;
      end else if (w_wr_ok && (wb_addr == w_rn)) begin
         read_data1 = wb_data;
      end else begin
         read_data1 = r_regs[w_rn];
      end
      if (w_r2 == XZR) begin
         read_data2 = '0;
      end else if (w_wr_ok && (wb_addr == w_r2)) begin
         read_data2 = wb_data;
      end else begin
         read_data2 = r_regs[w_r2];
      end
   end

   assign opcode    = r_ir[31:21];
   assign rd        = r_ir[4:0];
   assign pc_out    = r_pc;
   assign out_valid = r_v;

endmodule
